// File: rtl/apuf_xor_eval.sv
// rtl/apuf_xor_eval.sv - evaluation controller for parallel arbiter-PUF chains with repeated sampling and majority vote
// Latches a challenge, runs NREP clear/launch/sample rounds, XORs chain outputs and votes.
module apuf_xor_eval #(
   parameter int NSTAGE = 64,
   parameter int NCHAIN = 1,
   parameter int NREP   = 5,
   parameter int SETTLE = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NSTAGE-1:0]           chal_in,
   input  logic                        chal_valid,
   output logic                        chal_ready,
   output logic [NSTAGE-1:0]           sw_chal,
   output logic                        launch,
   output logic                        arb_clr,
   input  logic [NCHAIN-1:0]           arb_in,
   output logic                        resp,
   output logic [$clog2(NREP+1)-1:0]   ones_cnt,
   output logic                        resp_valid,
   input  logic                        resp_ready,
   output logic                        busy
);

   localparam int OW = $clog2(NREP + 1);
   localparam int RW = (NREP > 1) ? $clog2(NREP) : 1;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
   localparam logic [RW-1:0] REP_LAST = RW'(NREP - 1);
   localparam logic [OW:0]   NREP_W   = (OW + 1)'(NREP);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [RW-1:0]     rep_q, rep_d;
   logic [OW-1:0]     ones_q, ones_d;
   logic [NSTAGE-1:0] chal_q, chal_d;
   logic [OW:0]       ones_x2;
   logic              majority;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rep_d   = rep_q;
      ones_d  = ones_q;
      chal_d  = chal_q;
      case (state_q)
         S_IDLE: begin
            if (chal_valid) begin
               chal_d  = chal_in;
               rep_d   = '0;
               ones_d  = '0;
               cnt_d   = '0;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = S_RUN;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_RUN: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = S_SAMPLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_SAMPLE: begin
            // XOR across chains forms the response bit of one evaluation
            ones_d = ones_q + OW'(^arb_in);
            if (rep_q == REP_LAST) begin
               state_d = S_DONE;
            end else begin
               rep_d   = rep_q + RW'(1);
               state_d = S_CLEAR;
            end
         end
         S_DONE: begin
            if (resp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rep_q   <= '0;
         ones_q  <= '0;
         chal_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rep_q   <= rep_d;
         ones_q  <= ones_d;
         chal_q  <= chal_d;
      end
   end

   // Strict majority: an even-NREP tie votes 0
   assign ones_x2  = {ones_q, 1'b0};
   assign majority = (ones_x2 > NREP_W);

   always_comb begin
      sw_chal    = chal_q;
      launch     = 1'b0;
      arb_clr    = 1'b1;
      chal_ready = 1'b0;
      resp_valid = 1'b0;
      resp       = 1'b0;
      ones_cnt   = '0;
      busy       = (state_q != S_IDLE);
      case (state_q)
         S_IDLE: chal_ready = 1'b1;
         S_RUN, S_SAMPLE: begin
            launch  = 1'b1;
            arb_clr = 1'b0;
         end
         S_DONE: begin
            resp_valid = 1'b1;
            resp       = majority;
            ones_cnt   = ones_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_apuf_xor_eval.sv
// tb/tb_apuf_xor_eval.sv - self-checking bench for apuf_xor_eval against a cycle-index reference model
module tb_apuf_xor_eval;
   localparam int NSTAGE = 8;
   localparam int NCHAIN = 2;
   localparam int NREP   = 5;
   localparam int SETTLE = 2;
   localparam int P      = 2 * SETTLE + 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NSTAGE-1:0] chal_in = '0;
   logic              chal_valid = 1'b0;
   logic              chal_ready;
   logic [NSTAGE-1:0] sw_chal;
   logic              launch, arb_clr;
   logic [NCHAIN-1:0] arb_in = '0;
   logic              resp;
   logic [2:0]        ones_cnt;
   logic              resp_valid;
   logic              resp_ready = 1'b0;
   logic              busy;

   logic              chal_valid_b = 1'b0, resp_ready_b = 1'b0, arb_b = 1'b0;
   logic [NSTAGE-1:0] sw2, sw3;
   logic              cr2, cr3, l2, l3, c2, c3, r2, r3, rv2, rv3, b2, b3;
   logic [2:0]        oc2;
   logic [0:0]        oc3;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   apuf_xor_eval #(.NSTAGE(NSTAGE), .NCHAIN(NCHAIN), .NREP(NREP), .SETTLE(SETTLE)) dut (
      .clk(clk), .rst(rst), .chal_in(chal_in), .chal_valid(chal_valid), .chal_ready(chal_ready),
      .sw_chal(sw_chal), .launch(launch), .arb_clr(arb_clr), .arb_in(arb_in), .resp(resp),
      .ones_cnt(ones_cnt), .resp_valid(resp_valid), .resp_ready(resp_ready), .busy(busy));

   apuf_xor_eval #(.NSTAGE(NSTAGE), .NCHAIN(1), .NREP(4), .SETTLE(1)) u_tie (
      .clk(clk), .rst(rst), .chal_in(chal_in), .chal_valid(chal_valid_b), .chal_ready(cr2),
      .sw_chal(sw2), .launch(l2), .arb_clr(c2), .arb_in(arb_b), .resp(r2),
      .ones_cnt(oc2), .resp_valid(rv2), .resp_ready(resp_ready_b), .busy(b2));

   apuf_xor_eval #(.NSTAGE(NSTAGE), .NCHAIN(1), .NREP(1), .SETTLE(1)) u_one (
      .clk(clk), .rst(rst), .chal_in(chal_in), .chal_valid(chal_valid_b), .chal_ready(cr3),
      .sw_chal(sw3), .launch(l3), .arb_clr(c3), .arb_in(arb_b), .resp(r3),
      .ones_cnt(oc3), .resp_valid(rv3), .resp_ready(resp_ready_b), .busy(b3));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: mode 0 idle, 1 evaluating (m_k = cycles since accept), 2 response held
   int                m_mode = 0;
   int                m_k = 0;
   int                m_ones = 0;
   logic [NSTAGE-1:0] m_sw = '0;
   bit                m_on = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_on = 1; m_mode = 0; m_k = 0; m_ones = 0; m_sw = '0;
      end else begin
         case (m_mode)
            0: if (chal_valid) begin
                  m_sw = chal_in; m_ones = 0; m_k = 1; m_mode = 1;
               end
            1: begin
                  if ((m_k - 1) % P == 2 * SETTLE) m_ones += int'(^arb_in);
                  if (m_k == NREP * P) m_mode = 2;
                  else m_k++;
               end
            default: if (resp_ready) m_mode = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (m_on) begin
         bit e_launch;
         e_launch = (m_mode == 1) && ((m_k - 1) % P >= SETTLE);
         check("sw_chal", sw_chal, m_sw);
         check("launch", launch, e_launch);
         check("arb_clr", arb_clr, !e_launch);
         check("busy", busy, m_mode != 0);
         check("chal_ready", chal_ready, m_mode == 0);
         check("resp_valid", resp_valid, m_mode == 2);
         if (m_mode == 2) begin
            check("ones_cnt", ones_cnt, m_ones);
            check("resp", resp, (2 * m_ones) > NREP);
         end
      end
   end

   logic [1:0] tbl [5];
   bit         use_tbl = 1;

   function automatic int cur_rep();
      int r;
      r = (m_mode == 1) ? (m_k - 1) / P : 0;
      if (r > NREP - 1) r = NREP - 1;
      return r;
   endfunction

   task automatic step();
      @(negedge clk);
      if (use_tbl) arb_in = tbl[cur_rep()];
      else arb_in = NCHAIN'($urandom);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!resp_valid && n < 200) begin
         step();
         n++;
      end
      if (!resp_valid) check("done_timeout", 0, 1);
   endtask

   task automatic ack();
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
   endtask

   task automatic start(input logic [NSTAGE-1:0] c);
      chal_in = c;
      chal_valid = 1'b1;
      step();
      chal_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 5; i++) tbl[i] = 2'b01;
      step();
      step();
      rst = 1'b0;
      check("rst_chal_ready", chal_ready, 1);
      check("rst_arb_clr", arb_clr, 1);
      check("rst_launch", launch, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_sw_chal", sw_chal, 8'h00);
      check("rst_resp", resp, 0);
      check("rst_ones", ones_cnt, 0);

      // Tie (NREP=4) and single-shot (NREP=1) instances share stimulus
      chal_valid_b = 1'b1;
      for (int c = 1; c <= 13; c++) begin
         step();
         chal_valid_b = 1'b0;
         arb_b = (c <= 3) || (c >= 7 && c <= 9);
         if (c == 3)  check("one_rv_c3", rv3, 0);
         if (c == 4) begin
            check("one_rv_c4", rv3, 1);
            check("one_ones", oc3, 1);
            check("one_resp", r3, 1);
         end
         if (c == 12) check("tie_rv_c12", rv2, 0);
         if (c == 13) begin
            check("tie_rv_c13", rv2, 1);
            check("tie_ones", oc2, 2);
            check("tie_resp", r2, 0);
         end
      end
      resp_ready_b = 1'b1;

      // Timing with constant arb_in=01
      chal_in = 8'hA5;
      chal_valid = 1'b1;
      for (int c = 1; c <= 26; c++) begin
         step();
         chal_valid = 1'b0;
         if (c == 1)  check("t_sw_c1", sw_chal, 8'hA5);
         if (c == 2)  check("t_launch_c2", launch, 0);
         if (c == 3)  check("t_launch_c3", launch, 1);
         if (c == 5)  check("t_launch_c5", launch, 1);
         if (c == 6)  check("t_launch_c6", launch, 0);
         if (c == 8)  check("t_launch_c8", launch, 1);
         if (c == 25) check("t_rv_c25", resp_valid, 0);
         if (c == 26) begin
            check("t_rv_c26", resp_valid, 1);
            check("t_resp", resp, 1);
            check("t_ones", ones_cnt, 5);
         end
      end

      // Held response, new challenges ignored while not acknowledged
      for (int i = 0; i < 10; i++) begin
         chal_valid = 1'b1;
         chal_in = 8'($urandom);
         step();
      end
      check("hold_ones", ones_cnt, 5);
      check("hold_sw", sw_chal, 8'hA5);
      tbl[0] = 2'b11; tbl[1] = 2'b01; tbl[2] = 2'b00; tbl[3] = 2'b10; tbl[4] = 2'b11;
      chal_in = 8'h3C;
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      check("hs_idle_ready", chal_ready, 1);
      check("hs_idle_busy", busy, 0);
      step();
      chal_valid = 1'b0;
      check("hs_accept_busy", busy, 1);
      check("hs_accept_sw", sw_chal, 8'h3C);
      wait_done();
      check("vote1_ones", ones_cnt, 2);
      check("vote1_resp", resp, 0);
      ack();

      tbl[0] = 2'b01; tbl[1] = 2'b10; tbl[2] = 2'b11; tbl[3] = 2'b01; tbl[4] = 2'b00;
      start(8'hC3);
      wait_done();
      check("vote2_ones", ones_cnt, 3);
      check("vote2_resp", resp, 1);
      ack();

      // Reset during the third RUN phase
      start(8'h77);
      for (int i = 0; i < 12; i++) step();
      check("mid_launch_before", launch, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_launch_after", launch, 0);
      check("mid_busy_after", busy, 0);
      check("mid_sw_after", sw_chal, 8'h00);
      for (int i = 0; i < 30; i++) begin
         step();
         if (resp_valid) check("mid_no_resp", resp_valid, 0);
      end
      for (int i = 0; i < 5; i++) tbl[i] = 2'b11;
      start(8'h5A);
      wait_done();
      check("fresh_ones", ones_cnt, 0);
      check("fresh_resp", resp, 0);
      check("fresh_sw", sw_chal, 8'h5A);
      ack();

      // Randomized traffic with occasional resets
      use_tbl = 0;
      for (int i = 0; i < 4000; i++) begin
         chal_valid = 1'($urandom_range(0, 1));
         chal_in    = 8'($urandom);
         resp_ready = ($urandom_range(0, 3) == 0);
         rst        = ($urandom_range(0, 299) == 0);
         step();
      end
      rst = 1'b0;
      chal_valid = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
